// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-requester ALU arbiter.
// Opcodes, FSM states and result-class decode.
package alu_arbiter_pkg;

  localparam logic [3:0] OP_OR_RED  = 4'b0000;
  localparam logic [3:0] OP_AND_RED = 4'b0001;
  localparam logic [3:0] OP_XOR_RED = 4'b0010;
  localparam logic [3:0] OP_AND     = 4'b0011;
  localparam logic [3:0] OP_OR      = 4'b0100;
  localparam logic [3:0] OP_XOR     = 4'b0101;
  localparam logic [3:0] OP_GT      = 4'b0110;
  localparam logic [3:0] OP_LT      = 4'b0111;
  localparam logic [3:0] OP_EQ      = 4'b1000;
  localparam logic [3:0] OP_NE      = 4'b1001;
  localparam logic [3:0] OP_ADD     = 4'b1010;
  localparam logic [3:0] OP_SUB     = 4'b1011;
  localparam logic [3:0] OP_MUL     = 4'b1100;
  localparam logic [3:0] OP_SHL     = 4'b1101;
  localparam logic [3:0] OP_SHR     = 4'b1110;
  localparam logic [3:0] OP_NOT_B   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RC_BIT,
    RC_X_ONLY,
    RC_X_CARRY,
    RC_XY
  } res_class_t;

  function automatic res_class_t res_class(
    input logic [3:0] op
  );
    case (op)
      OP_OR_RED, OP_AND_RED, OP_XOR_RED,
      OP_GT, OP_LT, OP_EQ, OP_NE:
        res_class = RC_BIT;
      OP_ADD:
        res_class = RC_X_CARRY;
      OP_MUL, OP_SHL, OP_SHR:
        res_class = RC_XY;
      default:
        res_class = RC_X_ONLY;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response/ALU bundle for alu_arbiter.
// master = requesters + ALU side, slave = arbiter.
interface alu_arbiter_if;

  logic       req0_valid, req0_ready;
  logic [3:0] req0_opcode, req0_a, req0_b;
  logic       req1_valid, req1_ready;
  logic [3:0] req1_opcode, req1_a, req1_b;

  logic       rsp0_valid, rsp0_ready;
  logic [3:0] rsp0_x, rsp0_y;
  logic       rsp1_valid, rsp1_ready;
  logic [3:0] rsp1_x, rsp1_y;

  logic [3:0] alu_opcode, alu_a, alu_b;
  logic [3:0] alu_x, alu_y;
  logic       busy;

  modport master (
    output req0_valid, req0_opcode, req0_a, req0_b,
    output req1_valid, req1_opcode, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_x, rsp0_y,
    input  rsp1_valid, rsp1_x, rsp1_y,
    output rsp0_ready, rsp1_ready,
    input  alu_opcode, alu_a, alu_b,
    output alu_x, alu_y,
    input  busy
  );

  modport slave (
    input  req0_valid, req0_opcode, req0_a, req0_b,
    input  req1_valid, req1_opcode, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_x, rsp0_y,
    output rsp1_valid, rsp1_x, rsp1_y,
    input  rsp0_ready, rsp1_ready,
    output alu_opcode, alu_a, alu_b,
    input  alu_x, alu_y,
    output busy
  );

endinterface

// File: rtl/alu_result_norm.sv
// Masks stale ALU result bits according to opcode class.
// Purely combinational.
module alu_result_norm
  import alu_arbiter_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [3:0] alu_x,
  input  logic [3:0] alu_y,
  output logic [3:0] norm_x,
  output logic [3:0] norm_y
);

  res_class_t cls;

  always_comb begin
    cls    = res_class(opcode);
    norm_x = alu_x;
    norm_y = '0;
    unique case (1'b1)
      cls == RC_BIT:
        norm_x = {3'b0, alu_x[0]};
      cls == RC_X_ONLY:
        norm_x = alu_x;
      cls == RC_X_CARRY:
        norm_y = {3'b0, alu_y[0]};
      cls == RC_XY:
        norm_y = alu_y;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 4-bit ALU between two requesters.
// IDLE grants, EXEC holds operands, RESP waits for the taker.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  state_t     state, state_nxt;
  logic       rr, owner, win;
  logic       accept, rsp_hs;
  logic [3:0] norm_x, norm_y;
  logic [3:0] op_q, a_q, b_q;
  logic [3:0] x0_q, y0_q, x1_q, y1_q;

  alu_result_norm u_norm (
    .opcode (op_q),
    .alu_x  (bus.alu_x),
    .alu_y  (bus.alu_y),
    .norm_x (norm_x),
    .norm_y (norm_y)
  );

  always_comb begin
    win = 1'b0;
    if (bus.req0_valid && bus.req1_valid)
      win = RR_EN ? rr : 1'b0;
    else if (bus.req1_valid)
      win = 1'b1;
  end

  assign accept = (state == IDLE) &&
                  (bus.req0_valid || bus.req1_valid);
  assign rsp_hs = (state == RESP) &&
                  (owner ? bus.rsp1_ready : bus.rsp0_ready);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr    <= 1'b0;
      owner <= 1'b0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      x0_q  <= '0;
      y0_q  <= '0;
      x1_q  <= '0;
      y1_q  <= '0;
    end else begin
      if (accept) begin
        owner <= win;
        op_q  <= win ? bus.req1_opcode : bus.req0_opcode;
        a_q   <= win ? bus.req1_a : bus.req0_a;
        b_q   <= win ? bus.req1_b : bus.req0_b;
      end
      if (state == EXEC) begin
        if (owner) begin
          x1_q <= norm_x;
          y1_q <= norm_y;
        end else begin
          x0_q <= norm_x;
          y0_q <= norm_y;
        end
      end
      // Hand priority to the requester that was not just served
      if (rsp_hs && RR_EN)
        rr <= ~owner;
    end
  end

  assign bus.req0_ready = accept && !win;
  assign bus.req1_ready = accept && win;
  assign bus.rsp0_valid = (state == RESP) && !owner;
  assign bus.rsp1_valid = (state == RESP) && owner;
  assign bus.rsp0_x     = x0_q;
  assign bus.rsp0_y     = y0_q;
  assign bus.rsp1_x     = x1_q;
  assign bus.rsp1_y     = y1_q;
  assign bus.alu_opcode = op_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.busy       = (state != IDLE);

endmodule
